// File: rtl/csi_rx_pkg.sv
// Shared CSI RX definitions: default deskew geometry and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package csi_rx_pkg;

  localparam int DESKEW_MAX_DLY_DEF = 7;
  localparam int DESKEW_D_WIDTH_DEF = 8;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_deskew_dly_lane.sv
// One deskew lane: MAX_DLY-deep data/valid chain, tap mux and output register.
// Latency: 1 + dly enabled cycles from i_d/i_vld to o_q/o_vld.
// Backpressure: none; en=0 freezes every stage and the output register.
module deskew_lane
  import csi_rx_pkg::*;
#(
  parameter  int D_WIDTH = DESKEW_D_WIDTH_DEF,
  parameter  int MAX_DLY = DESKEW_MAX_DLY_DEF,
  localparam int DLY_W   = clog2(MAX_DLY + 1)
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               en,
  input  logic               clr,
  input  logic [DLY_W-1:0]   dly,
  input  logic               vld_mask,
  input  logic [D_WIDTH-1:0] i_d,
  input  logic               i_vld,
  output logic [D_WIDTH-1:0] o_q,
  output logic               o_vld
);

  logic [D_WIDTH-1:0] stg_d_q [MAX_DLY];
  logic               stg_v_q [MAX_DLY];
  logic [D_WIDTH-1:0] out_d_q;
  logic               out_v_q;
  logic [D_WIDTH-1:0] tap_d;
  logic               tap_v;

  // Tap select: dly=0 bypasses the chain, dly=k takes stage k-1.
  always_comb begin
    tap_d = i_d;
    tap_v = i_vld;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (dly == DLY_W'(k)) begin
        tap_d = stg_d_q[k-1];
        tap_v = stg_v_q[k-1];
      end
    end
  end

  // Chain shifts every enabled cycle regardless of valid; clear discards the current input too.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int k = 0; k < MAX_DLY; k++) begin
        stg_d_q[k] <= '0;
        stg_v_q[k] <= 1'b0;
      end
      out_d_q <= '0;
      out_v_q <= 1'b0;
    end else if (en) begin
      if (clr) begin
        for (int k = 0; k < MAX_DLY; k++) begin
          stg_d_q[k] <= '0;
          stg_v_q[k] <= 1'b0;
        end
        out_d_q <= '0;
        out_v_q <= 1'b0;
      end else begin
        stg_d_q[0] <= i_d;
        stg_v_q[0] <= i_vld;
        for (int k = 1; k < MAX_DLY; k++) begin
          stg_d_q[k] <= stg_d_q[k-1];
          stg_v_q[k] <= stg_v_q[k-1];
        end
        out_d_q <= tap_d;
        out_v_q <= tap_v & vld_mask;
      end
    end
  end

  assign o_q   = out_d_q;
  assign o_vld = out_v_q;

endmodule

// File: rtl/lane_deskew_dly.sv
// Multi-lane programmable deskew delay line with stall, clear, readback and post-write flush.
// Latency: 1 + o_dly[n] enabled cycles per lane; o_vld masked while o_busy after a delay write.
// Backpressure: none; i_en=0 is a global stall that freezes all state and samples nothing.
module lane_deskew_dly
  import csi_rx_pkg::*;
#(
  parameter  int D_WIDTH = DESKEW_D_WIDTH_DEF,
  parameter  int LANES   = 4,
  parameter  int MAX_DLY = DESKEW_MAX_DLY_DEF,
  localparam int DLY_W   = clog2(MAX_DLY + 1)
) (
  input  logic                     i_arst,
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_dly_wr,
  input  logic [LANES*DLY_W-1:0]   i_dly,
  input  logic [LANES-1:0]         i_vld,
  input  logic [LANES*D_WIDTH-1:0] i_d,
  output logic [LANES-1:0]         o_vld,
  output logic [LANES*D_WIDTH-1:0] o_q,
  output logic [LANES*DLY_W-1:0]   o_dly,
  output logic                     o_busy
);

  // Counter must hold MAX_DLY+1 so the flush outlasts the deepest tap plus the output register.
  localparam int                 CNT_W      = clog2(MAX_DLY + 2);
  localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(MAX_DLY + 1);
  localparam logic [DLY_W-1:0]   MAX_FLD    = DLY_W'(MAX_DLY);
  localparam logic [DLY_W:0]     MAX_CMP    = (DLY_W + 1)'(MAX_DLY);

  logic [LANES*DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0]       fld;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   lane_vld_mask;

  // Saturate each requested delay field to MAX_DLY on a write; otherwise keep the active set.
  always_comb begin
    dly_d = dly_q;
    fld   = '0;
    if (i_dly_wr) begin
      for (int n = 0; n < LANES; n++) begin
        fld = i_dly[n*DLY_W +: DLY_W];
        dly_d[n*DLY_W +: DLY_W] = ({1'b0, fld} > MAX_CMP) ? MAX_FLD : fld;
      end
    end
  end

  // Flush counter next state: clear beats a reload, a reload beats the countdown.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_dly_wr) begin
      cnt_d = FLUSH_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    busy_d = (cnt_d != '0);
  end

  // Delay, counter and busy registers advance only on enabled cycles.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      dly_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_en) begin
      dly_q  <= dly_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Mask from the next busy value so o_vld is 0 in exactly the cycles o_busy is 1.
  assign lane_vld_mask = ~busy_d;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    deskew_lane #(
      .D_WIDTH (D_WIDTH),
      .MAX_DLY (MAX_DLY)
    ) u_lane (
      .i_clk    (i_clk),
      .i_arst   (i_arst),
      .en       (i_en),
      .clr      (i_clr),
      .dly      (dly_q[n*DLY_W +: DLY_W]),
      .vld_mask (lane_vld_mask),
      .i_d      (i_d[n*D_WIDTH +: D_WIDTH]),
      .i_vld    (i_vld[n]),
      .o_q      (o_q[n*D_WIDTH +: D_WIDTH]),
      .o_vld    (o_vld[n])
    );
  end

  assign o_dly  = dly_q;
  assign o_busy = busy_q;

endmodule

// File: doc/lane_deskew_dly.md
Name: lane_deskew_dly

Overview:
- Multi-lane, runtime-programmable delay line. Successor to the fixed-depth single-channel shift register.
- Sits in the CSI RX path, between the per-lane byte aligners and the lane merger.
- Each lane's data and valid are delayed by its own programmable number of cycles, so the lanes can be deskewed.
- Adds a clock enable (stall), synchronous clear, delay readback and a flush/busy indication after a delay change.

Parameters:
- D_WIDTH, 8, data bits per lane.
- LANES, 4, number of lanes.
- MAX_DLY, 7, maximum programmable extra delay in cycles (≥1).
- DLY_W (localparam), clog2(MAX_DLY+1), width of one delay field.

Ports:
- i_arst  in  1  asynchronous reset, active-high.
- i_clk  in  1  clock.
- i_en  in  1  global clock enable. When 0, all state freezes.
- i_clr  in  1  synchronous clear of all data/valid stages. Qualified by i_en.
- i_dly_wr  in  1  load new delay settings. Qualified by i_en.
- i_dly  in  LANES*DLY_W  per-lane delay. Lane n occupies bits [n*DLY_W +: DLY_W].
- i_vld  in  LANES  per-lane input valid.
- i_d  in  LANES*D_WIDTH  per-lane input data. Lane n occupies bits [n*D_WIDTH +: D_WIDTH].
- o_vld  out  LANES  per-lane output valid.
- o_q  out  LANES*D_WIDTH  per-lane delayed data.
- o_dly  out  LANES*DLY_W  currently active (saturated) delay per lane.
- o_busy  out  1  high while a flush is in progress after a delay change.

Behaviour:
- Reset (i_arst high, asynchronous): all chain stages, o_q, o_vld, o_dly, the flush counter and o_busy go to 0.
- Reset release is synchronous to i_clk.
- Per lane, there is a chain of MAX_DLY stages plus one output register. Stages only advance when i_en=1.
- Data shifts every enabled cycle, regardless of i_vld. Valid bits shift alongside the data.
- Output register loads the selected tap:
  - dly=0 selects i_d/i_vld directly.
  - dly=k selects stage k-1.
- Latency: a sample entering in enabled cycle t appears on o_q/o_vld after exactly 1+dly enabled cycles.
- Stall: with i_en=0, o_q, o_vld, o_busy and the counter hold their values. No input is sampled.
- Delay write: on i_en & i_dly_wr, each field loads into its o_dly register.
  - Fields greater than MAX_DLY saturate to MAX_DLY.
  - The new tap is used from the next enabled cycle.
- Flush after a delay write (without clear):
  - Counter loads MAX_DLY+1 and o_busy=1 from the next cycle.
  - While busy, o_vld is forced to 0 and o_q still updates.
  - Counter decrements on each enabled cycle. o_busy drops when it reaches 0.
  - A write during busy reloads the counter.
- Clear: on i_en & i_clr, all stages, o_vld and o_q go to 0 on the next edge, and the counter and o_busy go to 0.
- Clear and delay write in the same cycle: delays load, chains clear, o_busy stays 0. Clear wins over flush.
- Clear has priority over shifting: the i_d presented in the clear cycle is discarded.
- Identical delays on all lanes keep the lanes in lockstep. Different delays shift each lane independently; no cross-lane interaction.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package csi_rx_pkg holds:
  - function clog2;
  - constants DESKEW_MAX_DLY_DEF=7 and DESKEW_D_WIDTH_DEF=8.
- Sub-module deskew_lane: one lane's data/valid chain, tap mux and output register. Ports: en, clr, dly, vld_mask.
- The top-level instantiates deskew_lane LANES times and owns the delay registers, saturation and flush counter.

Test Plan:
- Reset then zero delays:
  - Drive i_vld=1 and an incrementing byte on all lanes with i_en=1.
  - Required: o_q equals the input 1 cycle later and o_vld=1. All outputs are 0 during reset.
- Per-lane delays {0,3,5,7}:
  - Write the delays, wait until o_busy falls, then drive a single marker byte 0xA5 on all lanes.
  - Required: 0xA5 appears on lane n after 1/4/6/8 cycles respectively.
- Saturation and readback:
  - Write a delay of 15 on lane 2 (DLY_W=3 cannot hold it, so use MAX_DLY=5 and DLY_W=3, writing 7).
  - Required: o_dly lane2 = 5, and the marker latency is 6.
- Stall:
  - Deassert i_en for 4 cycles while a marker is mid-chain.
  - Required: outputs hold, and the marker emerges exactly 4 cycles late.
- Flush and clear:
  - Write delays, then assert i_clr 3 cycles into the busy window.
  - Required: o_busy goes 1 for 3 cycles, then 0 after the clear. o_vld=0 and o_q=0 the cycle after the clear.
  - Required: with simultaneous wr+clr, o_busy never rises.
- Asynchronous reset mid-stream:
  - Assert i_arst between clock edges with the chains full.
  - Required: o_q, o_vld, o_dly and o_busy go to 0 immediately, and valid data is output only after restart plus the latency.
